los_alarm_scan: RTL

- Time-shared LOS alarm integrator and event scheduler for the 42-channel E1 LOS vector recovered from the two LIU serial LOS streams.
- Snapshots the LOS vector once per scan period, then walks the channels one per clock, applying set/clear persistence thresholds.
- Each alarm state change is queued into a small event FIFO that the CPU interface drains with a valid/ready handshake.
- Sits between the LOS deserializer and the CPU/interrupt block, in the 38.88 MHz Ck domain.

---
 rtl/los_alarm_scan.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/los_alarm_scan.sv
// los_alarm_scan
// Time-shared LOS alarm integrator and event scheduler. The LOS vector is
// snapshotted once per scan period, then one channel is processed per clock
// against set/clear persistence thresholds. Each alarm change is queued in a
// small event FIFO, which the CPU side drains with a valid/ready handshake.
//
// State table:
//    IDLE | waiting for the scan tick; snapshot is taken on the tick
//    SCAN | processing channel idx, one channel per clock, NCH cycles total
//
// Ports:
//    Ck         system clock (38.88 MHz)
//    Rs         asynchronous reset, active low
//    scan_en    1 = scan tick generator runs, 0 = tick counter held at 0
//    los_in     raw LOS vector, bit n = channel n
//    ch_mask    1 = channel integrates but never queues events
//    evt_ready  consumer accepts the head event
//    ovf_clr    one-cycle pulse that clears the sticky overflow flag
//    los_alarm  debounced alarm state per channel
//    evt_valid  event FIFO not empty
//    evt_data   {channel index[5:0], new state} at the FIFO head
//    evt_ovf    sticky, an event was dropped
//    irq        registered evt_valid | evt_ovf
//    scan_busy  FSM is in SCAN
module los_alarm_scan #(
   parameter int NCH        = 42,
   parameter int SET_TH     = 8,
   parameter int CLR_TH     = 8,
   parameter int TICK_DIV   = 38880,
   parameter int FIFO_DEPTH = 8
) (
   input  logic           Ck,
   input  logic           Rs,
   input  logic           scan_en,
   input  logic [NCH-1:0] los_in,
   input  logic [NCH-1:0] ch_mask,
   input  logic           evt_ready,
   input  logic           ovf_clr,
   output logic [NCH-1:0] los_alarm,
   output logic           evt_valid,
   output logic [6:0]     evt_data,
   output logic           evt_ovf,
   output logic           irq,
   output logic           scan_busy
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   // FIFO_DEPTH is a power of two (>= 2) so the pointers wrap naturally.
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t         state_q, state_d;
   logic [TW-1:0]  tick_cnt;
   logic           tick;
   logic           proc;
   logic [IW-1:0]  idx;
   logic [NCH-1:0] snap;
   logic [NCH-1:0] alarm_q;
   logic [3:0]     cnt_q [NCH];

   logic           cur_a, cur_s;
   logic [3:0]     cur_c, th_m1;
   logic           flip, push;

   logic [6:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    count;
   logic           full, pop, wr_en, drop;

   // Scan period tick generator
   assign tick = scan_en && (tick_cnt == TW'(TICK_DIV - 1));

   always_ff @(posedge Ck or negedge Rs) begin
      if (!Rs)
         tick_cnt <= '0;
      else if (!scan_en || tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + TW'(1);
   end

   // FSM
   always_ff @(posedge Ck or negedge Rs) begin
      if (!Rs)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      proc    = 1'b0;
      case (state_q)
         IDLE: if (tick) state_d = SCAN;
         SCAN: begin
            proc = 1'b1;
            if (idx == IW'(NCH - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Ticks that land during SCAN are ignored because only IDLE looks at them.
   always_ff @(posedge Ck or negedge Rs) begin
      if (!Rs) begin
         snap <= '0;
         idx  <= '0;
      end else if (state_q == IDLE && tick) begin
         snap <= los_in;
         idx  <= '0;
      end else if (proc) begin
         idx  <= idx + IW'(1);
      end
   end

   // Per-channel persistence step
   assign cur_a = alarm_q[idx];
   assign cur_s = snap[idx];
   assign cur_c = cnt_q[idx];
   assign th_m1 = cur_a ? 4'(CLR_TH - 1) : 4'(SET_TH - 1);
   assign flip  = proc && (cur_s != cur_a) && (cur_c == th_m1);
   assign push  = flip && !ch_mask[idx];

   always_ff @(posedge Ck or negedge Rs) begin
      if (!Rs) begin
         alarm_q <= '0;
         for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      end else if (proc) begin
         if (cur_s == cur_a) begin
            cnt_q[idx] <= '0;
         end else if (cur_c == th_m1) begin
            alarm_q[idx] <= cur_s;
            cnt_q[idx]   <= '0;
         end else begin
            cnt_q[idx] <= cur_c + 4'd1;
         end
      end
   end

   // Event FIFO; a pop in the same cycle frees the slot for a push into a full FIFO.
   assign full  = (count == (AW+1)'(FIFO_DEPTH));
   assign pop   = evt_valid && evt_ready;
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   always_ff @(posedge Ck or negedge Rs) begin
      if (!Rs) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= {6'(idx), cur_s};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Overflow flag: a new drop beats a simultaneous clear.
   always_ff @(posedge Ck or negedge Rs) begin
      if (!Rs) begin
         evt_ovf <= 1'b0;
         irq     <= 1'b0;
      end else begin
         if (drop)
            evt_ovf <= 1'b1;
         else if (ovf_clr)
            evt_ovf <= 1'b0;
         irq <= evt_valid | evt_ovf;
      end
   end

   assign evt_valid = (count != '0);
   assign evt_data  = mem[rd_ptr];
   assign los_alarm = alarm_q;
   assign scan_busy = (state_q == SCAN);

endmodule
